alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, data path width in bits; legal values are powers of two from 8 to 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), number of shift-amount bits taken from b.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  4  operation select.
REQ-008 a  input  WIDTH  first operand.
REQ-009 b  input  WIDTH  second operand; for shifts, low SHW bits give the amount.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 flags  output  5  {illegal, ovf, carry, neg, zero}.

Function
REQ-014 Op encoding SHALL be:
- 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR.
- 5 SRA; 6 SRL; 7 SLL.
- 8 MUL (low WIDTH bits of a*b).
- 9 SLT (signed); 10 SLTU (unsigned).
- 11-15 illegal.
REQ-015 The block SHALL be an FSM with states IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1; a, b and op SHALL be captured at that edge.
REQ-017 Single-cycle ops (0-7, 9-15) SHALL go IDLE->DONE at the accept edge, so out_valid is 1 after one edge.
REQ-018 MUL SHALL go IDLE->BUSY at the accept edge and perform one shift-add step per BUSY edge under a step counter.
REQ-019 After the WIDTH-th BUSY edge, MUL SHALL go BUSY->DONE, giving a latency of WIDTH edges.
REQ-020 out_valid SHALL be 1 exactly in DONE.
REQ-021 result and flags SHALL hold stable in DONE until an edge with out_ready=1, which moves DONE->IDLE.
REQ-022 A new request SHALL NOT be accepted on the same edge that a result is released.
REQ-023 ADD/SUB arithmetic SHALL be modulo 2^WIDTH.
REQ-024 carry SHALL be:
- ADD: the carry-out.
- SUB: 1 when a>=b unsigned (no borrow).
- All other ops: 0.
REQ-025 ovf SHALL be the two's-complement signed overflow for ADD/SUB and 0 for all other ops.
REQ-026 zero SHALL be (result==0) and neg SHALL be result[WIDTH-1], for all ops.
REQ-027 Shift amount SHALL be b[SHW-1:0]; upper bits of b are ignored; an amount of 0 SHALL pass a through unchanged.
REQ-028 SRA SHALL replicate a[WIDTH-1] into vacated bits; SRL and SLL SHALL fill vacated bits with zeros.
REQ-029 SLT/SLTU SHALL return 1 or 0 zero-extended to WIDTH.
REQ-030 Illegal ops SHALL return result 0 with illegal=1, zero=1 and all other flags 0.
REQ-031 in_valid SHALL be ignored while BUSY or DONE; operand changes in those states SHALL NOT affect the result in flight.

Reset
REQ-032 While rst_n=0:
- state = IDLE; in_ready = 1.
- out_valid = 0; result = 0; flags = 0.
- step counter and operand registers = 0.
REQ-033 Reset asserted during BUSY or DONE SHALL abort the operation with no output produced.
REQ-034 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-035 A shared package alu_pkg SHALL hold:
- op encoding constants OP_ADD..OP_SLTU;
- the FSM state typedef;
- flag bit index constants.
REQ-036 The iterative multiplier SHALL be one sub-module, alu_mul_iter, with start/done handshake, parametrised by WIDTH.
REQ-037 All other ops SHALL be combinational logic inside alu_seq feeding the DONE registers.

Verification
REQ-038 ADD: a=128, b=2, out_ready=1 -> result=130, flags=0, out_valid one edge after accept.
REQ-039 SUB: a=2, b=128 -> result=0xFFFFFF82, neg=1, carry=0. ADD: a=0x7FFFFFFF, b=1 -> result=0x80000000, ovf=1.
REQ-040 Shifts with a=0x8000000F, b=0x22 (amount 2) -> SRA 0xE0000003, SRL 0x20000003, SLL 0x0000003C.
REQ-041 MUL: a=0x0000FFFF, b=0x00010001 -> result=0xFFFFFFFF after exactly 32 edges, in_ready=0 throughout.
REQ-042 Backpressure: hold out_ready=0 for 5 cycles after a result with operands changing -> result stable, no second accept, release on out_ready=1.
REQ-043 Reset mid-MUL at BUSY step 10 -> out_valid stays 0, in_ready=1, the next ADD completes correctly. op=12 -> result 0, illegal=1, zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op encoding, FSM state type and flag bit positions shared by the ALU block
package alu_pkg;
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SRA  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SLL  = 4'd7;
   localparam logic [3:0] OP_MUL  = 4'd8;
   localparam logic [3:0] OP_SLT  = 4'd9;
   localparam logic [3:0] OP_SLTU = 4'd10;

   localparam int F_ZERO  = 0;
   localparam int F_NEG   = 1;
   localparam int F_CARRY = 2;
   localparam int F_OVF   = 3;
   localparam int F_ILL   = 4;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one step per cycle, low WIDTH bits of a*b
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] prod
);
   localparam int CW = $clog2(WIDTH);
   logic [WIDTH-1:0] acc, mcand, mplier;
   logic [CW-1:0]    cnt;
   logic             busy;
   // prod is the accumulator after the current step, valid while done is high
   assign prod = acc + (mplier[0] ? mcand : '0);
   assign done = busy && cnt == CW'(WIDTH - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
      end else if (start) begin
         acc    <= '0;
         mcand  <= a;
         mplier <= b;
         cnt    <= '0;
         busy   <= 1'b1;
      end else if (busy) begin
         acc    <= prod;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         busy   <= !done;
      end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU; single-cycle ops finish at accept, MUL iterates WIDTH cycles
import alu_pkg::*;

module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [4:0]       flags
);
   state_t           state_q, state_d;
   logic             accept, mul_start, mul_done;
   logic [WIDTH-1:0] mul_prod, alu_r;
   logic [WIDTH:0]   sum, diff;
   logic [4:0]       alu_f, mul_f;
   logic             c, v, ill;

   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign accept    = in_ready && in_valid;
   assign mul_start = accept && op == OP_MUL;
   assign sum       = {1'b0, a} + {1'b0, b};
   assign diff      = {1'b0, a} - {1'b0, b};

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .start (mul_start),
      .a     (a),
      .b     (b),
      .done  (mul_done),
      .prod  (mul_prod)
   );

   always_comb begin
      alu_r = '0;
      c     = 1'b0;
      v     = 1'b0;
      ill   = 1'b0;
      case (op)
         OP_ADD: begin
            alu_r = sum[WIDTH-1:0];
            c     = sum[WIDTH];
            v     = a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
         end
         OP_SUB: begin
            alu_r = diff[WIDTH-1:0];
            c     = !diff[WIDTH];
            v     = a[WIDTH-1] != b[WIDTH-1] && diff[WIDTH-1] != a[WIDTH-1];
         end
         OP_AND:  alu_r = a & b;
         OP_OR:   alu_r = a | b;
         OP_XOR:  alu_r = a ^ b;
         OP_SRA:  alu_r = WIDTH'($signed(a) >>> b[SHW-1:0]);
         OP_SRL:  alu_r = a >> b[SHW-1:0];
         OP_SLL:  alu_r = a << b[SHW-1:0];
         OP_SLT:  alu_r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: alu_r = {{(WIDTH-1){1'b0}}, a < b};
         OP_MUL:  alu_r = '0;
         default: ill = 1'b1;
      endcase
      alu_f          = '0;
      alu_f[F_ZERO]  = alu_r == '0;
      alu_f[F_NEG]   = alu_r[WIDTH-1];
      alu_f[F_CARRY] = c;
      alu_f[F_OVF]   = v;
      alu_f[F_ILL]   = ill;
      mul_f          = '0;
      mul_f[F_ZERO]  = mul_prod == '0;
      mul_f[F_NEG]   = mul_prod[WIDTH-1];
   end

   // DONE->IDLE takes priority implicitly: in_ready is low in DONE, so no accept on release
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = accept ? (op == OP_MUL ? BUSY : DONE) : IDLE;
         BUSY:    state_d = mul_done ? DONE : BUSY;
         DONE:    state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         result  <= '0;
         flags   <= '0;
      end else begin
         state_q <= state_d;
         if (accept && op != OP_MUL) begin
            result <= alu_r;
            flags  <= alu_f;
         end else if (state_q == BUSY && mul_done) begin
            result <= mul_prod;
            flags  <= mul_f;
         end
      end
endmodule
